// File: rtl/proximity_pkg.sv
// Shared types and constants for the proximity monitor slice.
// Distance is carried in centimetres on a 12-bit bus.
package proximity_pkg;

    localparam int DIST_W = 12;

    typedef logic [DIST_W-1:0] distance_t;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        WAIT_RESULT,
        GAP
    } mon_state_t;

endpackage

// File: rtl/proximity_monitor_moving_avg_filter.sv
// Power-of-two moving average over accepted distance samples.
// Emits a registered average once the window has filled.
module moving_avg_filter
    import proximity_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  distance_t i_sample,
    input  logic      i_strobe,
    output distance_t o_avg,
    output logic      o_valid,
    output distance_t o_avg_next,
    output logic      o_load
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int SUM_W  = DIST_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    distance_t          r_win [N];
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   w_sum_next;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_next;
    distance_t          r_avg;
    logic               r_valid;

    // r_win[N-1] is the oldest entry; zero until the window fills
    always_comb begin
        w_sum_next  = r_sum + SUM_W'(i_sample) - SUM_W'(r_win[N-1]);
        w_fill_next = (r_fill == FILL_W'(N)) ? r_fill
                                              : r_fill + FILL_W'(1);
        o_load      = i_strobe && (w_fill_next == FILL_W'(N));
        o_avg_next  = w_sum_next[SUM_W-1:AVG_LOG2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_win[i] <= '0;
            end
            r_sum   <= '0;
            r_fill  <= '0;
            r_avg   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= o_load;
            if (i_strobe) begin
                r_win[0] <= i_sample;
                for (int i = 1; i < N; i++) begin
                    r_win[i] <= r_win[i-1];
                end
                r_sum  <= w_sum_next;
                r_fill <= w_fill_next;
            end
            if (o_load) begin
                r_avg <= o_avg_next;
            end
        end
    end

    assign o_avg   = r_avg;
    assign o_valid = r_valid;

endmodule

// File: rtl/proximity_monitor.sv
// Periodic measurement scheduler with echo timeout, smoothing
// and a hysteretic obstacle flag.
module proximity_monitor
    import proximity_pkg::*;
#(
    parameter int        PERIOD_CYCLES  = 3_000_000,
    parameter int        TIMEOUT_CYCLES = 2_500_000,
    parameter int        AVG_LOG2       = 2,
    parameter distance_t NEAR_CM        = 12'd20,
    parameter distance_t FAR_CM         = 12'd25
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      enable,
    output logic      measure,
    input  distance_t dist_in,
    input  logic      dist_valid,
    output distance_t avg_dist,
    output logic      avg_valid,
    output logic      obstacle,
    output logic      no_echo
);

    localparam int             CNT_W  = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_t       r_state;
    mon_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_no_echo;
    logic             r_obstacle;
    logic             w_accept;
    logic             w_timeout;
    distance_t        w_avg_next;
    logic             w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = FIRE;
                end
            end
            FIRE: begin
                w_state_next = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                // A sample arriving on the timeout cycle takes priority
                if (dist_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = GAP;
                end else if (r_cnt == T_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = GAP;
                end
            end
            GAP: begin
                if (r_cnt == P_LAST) begin
                    w_state_next = enable ? FIRE : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // One counter serves both period and timeout: both start at FIRE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == FIRE) begin
            r_cnt <= '0;
        end else if (r_state == WAIT_RESULT || r_state == GAP) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_no_echo  <= 1'b0;
            r_obstacle <= 1'b0;
        end else begin
            if (w_accept) begin
                r_no_echo <= 1'b0;
            end else if (w_timeout) begin
                r_no_echo <= 1'b1;
            end
            if (w_load) begin
                if (w_avg_next < NEAR_CM) begin
                    r_obstacle <= 1'b1;
                end else if (w_avg_next > FAR_CM) begin
                    r_obstacle <= 1'b0;
                end
            end
        end
    end

    moving_avg_filter #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sample   (dist_in),
        .i_strobe   (w_accept),
        .o_avg      (avg_dist),
        .o_valid    (avg_valid),
        .o_avg_next (w_avg_next),
        .o_load     (w_load)
    );

    assign measure  = (r_state == FIRE);
    assign obstacle = r_obstacle;
    assign no_echo  = r_no_echo;

endmodule

// File: tb/tb_proximity_monitor.sv
// Randomised bench for proximity_monitor against a queue-based
// model of the averaging window, hysteresis and measure schedule.
module tb_proximity_monitor;

    localparam int P = 100;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        dist_valid = 1'b0;
    logic [11:0] dist_in = '0;
    logic        measure;
    logic [11:0] avg_dist;
    logic        avg_valid;
    logic        obstacle;
    logic        no_echo;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int prev_meas = -1;

    int win[$];
    int m_avg = 0;
    int m_obst = 0;
    int m_noecho = 0;

    proximity_monitor #(
        .PERIOD_CYCLES  (P),
        .TIMEOUT_CYCLES (T),
        .AVG_LOG2       (2),
        .NEAR_CM        (12'd20),
        .FAR_CM         (12'd25)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .measure    (measure),
        .dist_in    (dist_in),
        .dist_valid (dist_valid),
        .avg_dist   (avg_dist),
        .avg_valid  (avg_valid),
        .obstacle   (obstacle),
        .no_echo    (no_echo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_sample(input int v, output int ev);
        int sum;
        win.push_back(v);
        if (win.size() > 4) void'(win.pop_front());
        ev = (win.size() == 4) ? 1 : 0;
        if (ev == 1) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            m_avg = sum / 4;
            if (m_avg < 20) m_obst = 1;
            else if (m_avg > 25) m_obst = 0;
        end
        m_noecho = 0;
    endtask

    task automatic model_reset();
        win.delete();
        m_avg = 0;
        m_obst = 0;
        m_noecho = 0;
        prev_meas = -1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_measure"}, measure, 0);
        check({tag, "_avg_dist"}, avg_dist, 0);
        check({tag, "_avg_valid"}, avg_valid, 0);
        check({tag, "_obstacle"}, obstacle, 0);
        check({tag, "_no_echo"}, no_echo, 0);
    endtask

    task automatic wait_measure();
        int n;
        n = 0;
        while (measure !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (measure !== 1'b1) begin
            check("measure_seen", 0, 1);
        end else begin
            if (prev_meas >= 0) check("meas_gap", cyc - prev_meas, P + 1);
            prev_meas = cyc;
        end
    endtask

    task automatic answer(input int d, input int v, input bit drop_en);
        int ev;
        wait_measure();
        @(negedge clk);
        check("meas_width", measure, 0);
        if (drop_en) enable = 1'b0;
        repeat (d - 1) @(negedge clk);
        check("pre_no_echo", no_echo, m_noecho);
        check("pre_avg", avg_dist, m_avg);
        dist_valid = 1'b1;
        dist_in = 12'(v);
        @(negedge clk);
        dist_valid = 1'b0;
        model_sample(v, ev);
        check("avg_valid", avg_valid, ev);
        check("avg_dist", avg_dist, m_avg);
        check("obstacle", obstacle, m_obst);
        check("no_echo_clr", no_echo, 0);
        @(negedge clk);
        check("avg_valid_pulse", avg_valid, 0);
    endtask

    task automatic miss();
        wait_measure();
        @(negedge clk);
        check("meas_width", measure, 0);
        repeat (T - 1) @(negedge clk);
        check("no_echo_early", no_echo, m_noecho);
        @(negedge clk);
        m_noecho = 1;
        check("no_echo_set", no_echo, 1);
        check("to_avg_valid", avg_valid, 0);
        check("to_avg_dist", avg_dist, m_avg);
        check("to_obstacle", obstacle, m_obst);
        dist_valid = 1'b1;
        dist_in = 12'd5;
        @(negedge clk);
        dist_valid = 1'b0;
        check("stray_ignored", avg_valid, 0);
    endtask

    initial begin
        int seq[13] = '{40, 40, 40, 40, 10, 10, 10, 10, 22, 22, 22, 22, 40};
        int seen;

        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_meas", measure, 0);

        enable = 1'b1;
        @(negedge clk);
        check("first_meas", measure, 1);

        foreach (seq[i]) answer($urandom_range(1, T), seq[i], 1'b0);

        miss();
        answer($urandom_range(1, T), 30, 1'b0);
        answer(T, 35, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) miss();
            else answer($urandom_range(1, T), $urandom_range(0, 60), 1'b0);
        end

        answer($urandom_range(1, T), 18, 1'b1);
        seen = 0;
        repeat (250) begin
            @(negedge clk);
            if (measure) seen++;
        end
        check("no_meas_after_drop", seen, 0);
        prev_meas = -1;

        enable = 1'b1;
        @(negedge clk);
        check("reenable_meas", measure, 1);
        answer($urandom_range(1, T), 12, 1'b0);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("gap_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (measure) seen++;
        end
        check("no_meas_after_rst", seen, 0);

        enable = 1'b1;
        @(negedge clk);
        check("post_rst_meas", measure, 1);
        rst_n = 1'b0;
        #1;
        check("meas_async_drop", measure, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        answer(10, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
